// File: rtl/reset_stage_sequencer.sv
// One stage of a chained reset sequence: asserts reset on start/clear, releases it
// after a fixed hold or after rdone qualifies, then raises sdone once rdone is stable.
module reset_stage_sequencer #(
  parameter int reset_hold_til_rdone = 0,
  parameter int reset_hold_cycles    = 1,
  parameter int sdone_delay_cycles   = 0
) (
  input  logic clock,
  input  logic clr_n,
  input  logic start,
  input  logic rdone,
  output logic reset,
  output logic sdone
);

  localparam bit TIL = (reset_hold_til_rdone != 0);
  localparam int HW  = (reset_hold_cycles < 1) ? 1 : $clog2(reset_hold_cycles + 1);
  localparam int DW  = (sdone_delay_cycles < 1) ? 1 : $clog2(sdone_delay_cycles + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(reset_hold_cycles - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(sdone_delay_cycles);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            reset_q, reset_d;
  logic            sdone_q, sdone_d;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    dcnt_d  = dcnt_q;
    if (start) begin
      state_d = ST_ASSERT;
      hcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (TIL || hcnt_q == HOLD_LAST) state_d = ST_WAIT;
          else                            hcnt_d  = hcnt_q + HW'(1);
        end
        ST_WAIT: begin
          if (!rdone)                  dcnt_d  = '0;
          else if (dcnt_q == DLY_LAST) state_d = ST_DONE;
          else                         dcnt_d  = dcnt_q + DW'(1);
        end
        ST_DONE: state_d = ST_DONE;
        default: begin
          state_d = ST_ASSERT;
          hcnt_d  = '0;
          dcnt_d  = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they register alongside it.
    reset_d = (state_d == ST_ASSERT) || (TIL && state_d == ST_WAIT);
    sdone_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      state_q <= ST_ASSERT;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      reset_q <= 1'b1;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      reset_q <= reset_d;
      sdone_q <= sdone_d;
    end
  end

  assign reset = reset_q;
  assign sdone = sdone_q;

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Bench for reset_stage_sequencer: five instances (hold, til-rdone, two-stage chain)
// checked every cycle against a run-length timeline model plus literal expectations.
module tb_reset_stage_sequencer;

  logic       clock = 1'b0;
  logic       clr_n, start, rdone;
  logic [4:0] rst_w, sd_w;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Instance configs: 0 hold3/d0, 1 til/d8, 2 hold5/d2, 3 chain stage1 til/d0, 4 chain stage2 til/d0
  int   m_til[5] = '{0, 1, 0, 1, 1};
  int   m_h[5]   = '{3, 1, 5, 1, 1};
  int   m_d[5]   = '{0, 8, 2, 0, 0};
  int   m_since[5];
  int   m_run[5];
  bit   m_done[5];
  logic m_rst[5];
  logic m_sd[5];

  always #5 clock = ~clock;

  reset_stage_sequencer #(.reset_hold_til_rdone(0), .reset_hold_cycles(3), .sdone_delay_cycles(0)) u_a (
    .clock(clock), .clr_n(clr_n), .start(start), .rdone(rdone), .reset(rst_w[0]), .sdone(sd_w[0]));
  reset_stage_sequencer #(.reset_hold_til_rdone(1), .reset_hold_cycles(1), .sdone_delay_cycles(8)) u_b (
    .clock(clock), .clr_n(clr_n), .start(start), .rdone(rdone), .reset(rst_w[1]), .sdone(sd_w[1]));
  reset_stage_sequencer #(.reset_hold_til_rdone(0), .reset_hold_cycles(5), .sdone_delay_cycles(2)) u_d (
    .clock(clock), .clr_n(clr_n), .start(start), .rdone(rdone), .reset(rst_w[2]), .sdone(sd_w[2]));
  reset_stage_sequencer #(.reset_hold_til_rdone(1), .reset_hold_cycles(1), .sdone_delay_cycles(0)) u_c1 (
    .clock(clock), .clr_n(clr_n), .start(start), .rdone(rdone), .reset(rst_w[3]), .sdone(sd_w[3]));
  reset_stage_sequencer #(.reset_hold_til_rdone(1), .reset_hold_cycles(1), .sdone_delay_cycles(0)) u_c2 (
    .clock(clock), .clr_n(clr_n), .start(start), .rdone(sd_w[3]), .reset(rst_w[4]), .sdone(sd_w[4]));

  // Timeline model: edges since the last restart decide the hold window; a run
  // length of rdone-high edges after that window decides completion.
  always @(posedge clock) begin
    logic up_sd;
    logic rd;
    int   win;
    up_sd = m_sd[3];
    for (int i = 0; i < 5; i++) begin
      rd  = (i == 4) ? up_sd : rdone;
      win = (m_til[i] != 0) ? 1 : m_h[i];
      if (!clr_n || start) begin
        m_since[i] = 0;
        m_run[i]   = 0;
        m_done[i]  = 1'b0;
      end else if (!m_done[i]) begin
        if (m_since[i] >= win) begin
          m_run[i] = rd ? m_run[i] + 1 : 0;
          if (m_run[i] == m_d[i] + 1) m_done[i] = 1'b1;
        end
        if (m_since[i] < 1000) m_since[i] = m_since[i] + 1;
      end
      m_sd[i]  = m_done[i];
      m_rst[i] = !m_done[i] && ((m_til[i] != 0) || (m_since[i] < m_h[i]));
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (rst_w[i] !== m_rst[i]) begin
          miscompares++;
          $display("FAIL model_reset[%0d] t=%0t got %b want %b", i, $time, rst_w[i], m_rst[i]);
        end
        vectors++;
        if (sd_w[i] !== m_sd[i]) begin
          miscompares++;
          $display("FAIL model_sdone[%0d] t=%0t got %b want %b", i, $time, sd_w[i], m_sd[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; rdone = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("clr_reset", rst_w[0], 1'b1);
    chk("clr_sdone", sd_w[0], 1'b0);
    tick();
    clr_n = 1'b1;
    tick(); chk("rel1_reset", rst_w[0], 1'b1);
    tick(); chk("rel2_reset", rst_w[0], 1'b1);
    tick(); chk("rel3_reset", rst_w[0], 1'b0); chk("rel3_sdone", sd_w[0], 1'b0);
    tick(); chk("rel4_sdone", sd_w[0], 1'b1); chk("rel4_reset", rst_w[0], 1'b0);

    // hold-count pulse from DONE
    start = 1'b1; tick(); start = 1'b0;
    chk("pulse_reset", rst_w[0], 1'b1); chk("pulse_sdone", sd_w[0], 1'b0);
    tick(); chk("pulse_h2", rst_w[0], 1'b1);
    tick(); chk("pulse_h3", rst_w[0], 1'b1);
    tick(); chk("pulse_rel", rst_w[0], 1'b0); chk("pulse_rel_sdone", sd_w[0], 1'b0);
    tick(); chk("pulse_done", sd_w[0], 1'b1);

    // til-rdone with delay 8
    rdone = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("til_hold_reset", rst_w[1], 1'b1); chk("til_hold_sdone", sd_w[1], 1'b0);
    rdone = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(); chk("til_wait_reset", rst_w[1], 1'b1);
    end
    tick(); chk("til_rel_reset", rst_w[1], 1'b0); chk("til_rel_sdone", sd_w[1], 1'b1);
    rdone = 1'b0; tick(); chk("til_stay_done", sd_w[1], 1'b1);

    // rdone glitch restarts the qualification
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    rdone = 1'b1; for (int k = 0; k < 4; k++) tick();
    rdone = 1'b0; tick();
    rdone = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(); chk("glitch_sdone_low", sd_w[1], 1'b0);
    end
    tick(); chk("glitch_sdone_high", sd_w[1], 1'b1); chk("glitch_reset_low", rst_w[1], 1'b0);

    // two-stage chain latency
    rdone = 1'b0; start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
    rdone = 1'b1;
    tick(); chk("chain_s1_sdone", sd_w[3], 1'b1); chk("chain_s2_reset_hi", rst_w[4], 1'b1);
    tick(); chk("chain_s2_reset_lo", rst_w[4], 1'b0); chk("chain_s2_sdone", sd_w[4], 1'b1);

    // restart held for 5 cycles from DONE
    for (int k = 0; k < 10; k++) tick();
    chk("pre_restart_done", sd_w[0], 1'b1);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("restart_reset", rst_w[0], 1'b1); chk("restart_sdone", sd_w[0], 1'b0);
    end
    start = 1'b0; rdone = 1'b0;
    tick(); chk("restart_h2", rst_w[0], 1'b1);
    tick(); chk("restart_h3", rst_w[0], 1'b1);
    tick(); chk("restart_wait", rst_w[0], 1'b0);

    // clear during WAIT clears the hold counter
    clr_n = 1'b0; tick(); clr_n = 1'b1;
    chk("wclr_reset", rst_w[0], 1'b1);
    tick(); chk("wclr_h2", rst_w[0], 1'b1);
    tick(); chk("wclr_h3", rst_w[0], 1'b1);
    tick(); chk("wclr_wait", rst_w[0], 1'b0);

    // randomized phase, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(15) == 0);
      clr_n = ($urandom_range(63) != 0);
      if ($urandom_range(5) == 0) rdone = ~rdone;
      tick();
    end

    @(posedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
